// File: rtl/sar_adc_pkg.sv
// -----------------------------------------------------------------------------
// sar_adc_pkg
// Shared definitions for the sar_adc_rnm real-number SAR ADC model.
//   state_e    : controller states (ST_SAMPLE is used only when the
//                SAR_ADC_AVG_EN averaging build is selected)
//   DEF_NBITS  : default converter resolution
//   lsb_volts(): weight of one code step for a given reference and resolution
// -----------------------------------------------------------------------------
package sar_adc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SAMPLE = 2'd1,
      ST_CONV   = 2'd2
   } state_e;

   localparam int DEF_NBITS = 10;

   function automatic real lsb_volts(input real vref, input int nbits);
      return vref / (2.0 ** nbits);
   endfunction

endpackage

// File: rtl/sar_adc_dac_cmp.sv
// -----------------------------------------------------------------------------
// sar_adc_dac_cmp
// Behavioural DAC + comparator for the SAR loop. Converts the trial code to
// its threshold voltage (trial * LSB) and decides whether the held input
// reaches it.
// Ports:
//   trial  in  NBITS  trial code (current result with the bit under test set)
//   vhold  in  real   held input voltage
//   keep   out 1      1 when vhold >= trial * LSB, i.e. the bit under test stays
// -----------------------------------------------------------------------------
module sar_adc_dac_cmp
   import sar_adc_pkg::*;
#(
   parameter int  NBITS = DEF_NBITS,
   parameter real VREF  = 1.0
) (
   input  logic [NBITS-1:0] trial,
   input  real              vhold,
   output logic             keep
);

   localparam real LSB = lsb_volts(VREF, NBITS);

   always_comb begin
      keep = (vhold >= (real'(trial) * LSB));
   end

endmodule

// File: rtl/sar_adc_rnm.sv
// -----------------------------------------------------------------------------
// sar_adc_rnm
// Real-number model of a successive-approximation ADC. A start in IDLE
// captures vin, then one bit is resolved per clock, MSB first. The finished
// code is presented with a one-cycle code_valid pulse and held until the next
// result or reset.
// Optional feature (macro SAR_ADC_AVG_EN): each start runs four conversions,
// re-sampling vin in a one-cycle SAMPLE state between them, and reports the
// truncated mean of the four codes with the OR of their range flags.
// Ports:
//   clk        in   1      conversion clock, all state on posedge
//   rst        in   1      asynchronous active-high reset
//   start      in   1      conversion request, honoured only in IDLE
//   vin        in   real   analog input
//   busy       out  1      high while a conversion is in progress
//   code       out  NBITS  unsigned result, held between conversions
//   code_valid out  1      one-cycle pulse when code/ovr update
//   ovr        out  1      input was below 0 or at/above VREF
// -----------------------------------------------------------------------------
module sar_adc_rnm
   import sar_adc_pkg::*;
#(
   parameter int  NBITS = DEF_NBITS,
   parameter real VREF  = 1.0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  real              vin,
   output logic             busy,
   output logic [NBITS-1:0] code,
   output logic             code_valid,
   output logic             ovr
);

   localparam logic [NBITS-1:0] MSB_BIT = {1'b1, {(NBITS-1){1'b0}}};

   state_e           state_q, state_d;
   real              vhold_q, vhold_d;
   logic [NBITS-1:0] bit_q, bit_d;
   logic [NBITS-1:0] result_q, result_d;
   logic [NBITS-1:0] code_q, code_d;
   logic             valid_q, valid_d;
   logic             ovr_q, ovr_d;

   logic [NBITS-1:0] trial;
   logic [NBITS-1:0] decided;
   logic             keep;
   logic             range_flag;

`ifdef SAR_ADC_AVG_EN
   logic [1:0]       cnt_q, cnt_d;
   logic [NBITS+1:0] acc_q, acc_d;
   logic [NBITS+1:0] sum;
   logic             ovr_acc_q, ovr_acc_d;
`endif

   assign trial = result_q | bit_q;

   sar_adc_dac_cmp #(
      .NBITS (NBITS),
      .VREF  (VREF)
   ) u_dac_cmp (
      .trial (trial),
      .vhold (vhold_q),
      .keep  (keep)
   );

   // Result after this cycle's decision. Out-of-range inputs clamp naturally:
   // below 0 no threshold is reached, at/above VREF every threshold is.
   assign decided    = keep ? trial : result_q;
   assign range_flag = (vhold_q < 0.0) || (vhold_q >= VREF);

`ifdef SAR_ADC_AVG_EN
   assign sum = acc_q + {2'b00, decided};
`endif

   always_comb begin
      state_d  = state_q;
      vhold_d  = vhold_q;
      bit_d    = bit_q;
      result_d = result_q;
      code_d   = code_q;
      ovr_d    = ovr_q;
      valid_d  = 1'b0;
`ifdef SAR_ADC_AVG_EN
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      ovr_acc_d = ovr_acc_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               vhold_d  = vin;
               bit_d    = MSB_BIT;
               result_d = '0;
               state_d  = ST_CONV;
`ifdef SAR_ADC_AVG_EN
               cnt_d     = 2'd0;
               acc_d     = '0;
               ovr_acc_d = 1'b0;
`endif
            end
         end
`ifdef SAR_ADC_AVG_EN
         ST_SAMPLE: begin
            vhold_d  = vin;
            bit_d    = MSB_BIT;
            result_d = '0;
            state_d  = ST_CONV;
         end
`endif
         ST_CONV: begin
            result_d = decided;
            bit_d    = bit_q >> 1;
            // bit_q[0] set means this edge resolves the LSB
            if (bit_q[0]) begin
`ifdef SAR_ADC_AVG_EN
               if (cnt_q == 2'd3) begin
                  code_d  = sum[NBITS+1:2];
                  ovr_d   = ovr_acc_q | range_flag;
                  valid_d = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  acc_d     = sum;
                  ovr_acc_d = ovr_acc_q | range_flag;
                  cnt_d     = cnt_q + 2'd1;
                  state_d   = ST_SAMPLE;
               end
`else
               code_d  = decided;
               ovr_d   = range_flag;
               valid_d = 1'b1;
               state_d = ST_IDLE;
`endif
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         vhold_q  <= 0.0;
         bit_q    <= '0;
         result_q <= '0;
         code_q   <= '0;
         valid_q  <= 1'b0;
         ovr_q    <= 1'b0;
`ifdef SAR_ADC_AVG_EN
         cnt_q     <= 2'd0;
         acc_q     <= '0;
         ovr_acc_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         vhold_q  <= vhold_d;
         bit_q    <= bit_d;
         result_q <= result_d;
         code_q   <= code_d;
         valid_q  <= valid_d;
         ovr_q    <= ovr_d;
`ifdef SAR_ADC_AVG_EN
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         ovr_acc_q <= ovr_acc_d;
`endif
      end
   end

   assign busy       = (state_q != ST_IDLE);
   assign code       = code_q;
   assign code_valid = valid_q;
   assign ovr        = ovr_q;

endmodule
